// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the multi-cycle MIPS datapath: address width,
//   requester indices of the shared adder and a signed-overflow helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int ADDR_BITS = 32;

    // Requester indices on the shared adder
    localparam int REQ_PC    = 0;
    localparam int REQ_BR    = 1;
    localparam int REQ_MEM   = 2;
    localparam int N_ADD_REQ = 3;

    // Two's-complement overflow: operands agree in sign, the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/Add_module.sv
// -----------------------------------------------------------------------------
// Add_module
//   Plain Bits-wide adder, result wraps modulo 2^Bits.
//   Ports: a_i, b_i  operands
//          sum_o     a_i + b_i truncated to Bits
// -----------------------------------------------------------------------------
module Add_module #(
    parameter int Bits = 32
) (
    input  logic [Bits-1:0] a_i,
    input  logic [Bits-1:0] b_i,
    output logic [Bits-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
//   Combinational round-robin pick: the first set bit of req, searching
//   circularly from (last+1) mod N.
//   Ports: req     request vector
//          last    index of the previous grant
//          gnt     one-hot grant
//          gnt_id  binary index of the grant
//          any     at least one request is set
// -----------------------------------------------------------------------------
module rr_grant #(
    parameter int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          any
);

    // Circular scan starting just after the previous winner; first hit wins.
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IW'(idx);
                any      = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//   One signed adder shared by N_REQ requesters through a round-robin grant.
//   The sum of the granted operands is registered in a one-deep result
//   register with valid/ready handshake.
//   Ports: clk, rst               clock, synchronous active-high reset
//          req_valid/req_ready    per-requester handshake (ready is one-hot)
//          req_a, req_b           flattened operands, requester i at [i*Bits +: Bits]
//          resp_valid/resp_ready  result handshake
//          resp_id, resp_sum,     requester index, wrapped sum and signed
//          resp_ovf               overflow flag of the presented result
// -----------------------------------------------------------------------------
module adder_rr_arbiter
    import mips_pkg::*;
#(
    parameter int Bits  = ADDR_BITS,
    parameter int N_REQ = N_ADD_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*Bits-1:0] req_a,
    input  logic [N_REQ*Bits-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [Bits-1:0]       resp_sum,
    output logic                  resp_ovf
);

    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic             any_s;
    logic             can_accept_s;
    logic             xfer_s;
    logic [Bits-1:0]  a_sel_s;
    logic [Bits-1:0]  b_sel_s;
    logic [Bits-1:0]  sum_s;

    logic             resp_valid_q, resp_valid_d;
    logic [Bits-1:0]  resp_sum_q,   resp_sum_d;
    logic [ID_W-1:0]  resp_id_q,    resp_id_d;
    logic             resp_ovf_q,   resp_ovf_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;

    rr_grant #(.N(N_REQ)) u_grant (
        .req    (req_valid),
        .last   (last_grant_q),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s),
        .any    (any_s)
    );

    // The grant never looks at the operand buses; they only feed the mux.
    assign a_sel_s = req_a[gnt_id_s*Bits +: Bits];
    assign b_sel_s = req_b[gnt_id_s*Bits +: Bits];

    Add_module #(.Bits(Bits)) u_add (
        .a_i   (a_sel_s),
        .b_i   (b_sel_s),
        .sum_o (sum_s)
    );

    // The result slot is free when empty or being drained this cycle.
    assign can_accept_s = !resp_valid_q || resp_ready;
    assign xfer_s       = !rst && can_accept_s && any_s;

    // Grant is only exposed while a transfer can actually happen.
    always_comb begin
        req_ready = '0;
        if (xfer_s) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    // Result register next state: load on transfer, clear valid on drain.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_id_d    = resp_id_q;
        resp_ovf_d   = resp_ovf_q;
        last_grant_d = last_grant_q;
        if (xfer_s) begin
            resp_valid_d = 1'b1;
            resp_sum_d   = sum_s;
            resp_id_d    = gnt_id_s;
            resp_ovf_d   = add_ovf(a_sel_s[Bits-1], b_sel_s[Bits-1], sum_s[Bits-1]);
            last_grant_d = gnt_id_s;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // State registers; last_grant resets to N_REQ-1 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_id_q    <= '0;
            resp_ovf_q   <= 1'b0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_id_q    <= resp_id_d;
            resp_ovf_q   <= resp_ovf_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;
    assign resp_ovf   = resp_ovf_q;

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Shares one signed `Bits`-wide adder among `N_REQ` requesters, such as PC+4, branch target, and load/store effective address, in the multi-cycle datapath variant. Each cycle, a round-robin arbiter grants at most one valid request. The selected operands are added, and the registered sum is returned with the requester ID through a one-deep output register with valid/ready flow control.

## Interface
- `Bits`, 32, operand/sum width (signed, two's complement)
- `N_REQ`, 3, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)`, width of `resp_id` (derived; do not override)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  `N_REQ`  per-requester request strobe
- `req_a`  in  `N_REQ*Bits`  flattened operand A; requester i occupies `[i*Bits +: Bits]`
- `req_b`  in  `N_REQ*Bits`  flattened operand B, same packing
- `req_ready`  out  `N_REQ`  one-hot grant/accept; at most one bit high
- `resp_valid`  out  1  result register holds a valid sum
- `resp_ready`  in  1  consumer accepts the result
- `resp_id`  out  `ID_W`  index of the requester whose sum is presented
- `resp_sum`  out  `Bits`  `a+b`, truncated to `Bits`
- `resp_ovf`  out  1  signed overflow of that addition

## Operation
- Accept window:
  - `can_accept = !resp_valid || resp_ready`.
  - When `can_accept` is 0, all `req_ready` bits are 0.
- Grant:
  - When `can_accept` is 1 and `req_valid != 0`, grant the first set bit of `req_valid`, searching circularly from `(last_grant+1) mod N_REQ`.
  - `req_ready[g]=1` combinationally in the same cycle.
  - A transfer occurs when `req_valid[g] && req_ready[g]`.
- On transfer, at the rising edge:
  - `resp_sum <= a_g + b_g`
  - `resp_id <= g`
  - `resp_ovf <= (a_g[MSB]==b_g[MSB]) && (sum[MSB]!=a_g[MSB])`
  - `resp_valid <= 1`
  - `last_grant <= g`
- Result consumed, no new transfer: `resp_valid <= 0`. `resp_sum`, `resp_id` and `resp_ovf` hold their last values.
- Simultaneous consume and transfer: the new result replaces the old one with no bubble, sustaining one result per cycle.
- Requester rules:
  - Hold `req_valid`, `req_a` and `req_b` stable until `req_ready`.
  - `req_valid` must not depend combinationally on `req_ready`.
  - The arbiter drops nothing, and a waiting request stays pending.
- Fairness: a continuously asserted requester is granted within `N_REQ` accept-window cycles.
- Arithmetic: wrap-around modulo `2^Bits`. No saturation. `resp_ovf` is informational only.

## Timing
- Latency: the result is visible exactly 1 cycle after the transfer edge.
- Throughput: 1 transfer/cycle while `resp_ready` stays high.
- Backpressure: while `resp_valid && !resp_ready`, outputs are frozen and no grant is issued.
- Reset values: `resp_valid=0`, `resp_sum=0`, `resp_id=0`, `resp_ovf=0`, `last_grant=N_REQ-1`, so requester 0 has first priority after reset. `req_ready` follows combinationally and is 0 during `rst`.
- Reset mid-operation: any pending result is discarded and not replayed. Requests asserted during the reset cycle are not accepted.
- `req_ready` depends combinationally on `req_valid`, `resp_valid`, `resp_ready` and `last_grant`. It must not depend on the operand buses.

## Structure
- Shared package `mips_pkg`:
  - `ADDR_BITS=32`
  - requester index constants `REQ_PC=0`, `REQ_BR=1`, `REQ_MEM=2`
  - `N_ADD_REQ=3`
- Sub-module `rr_grant`:
  - Parameter `N`.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: one-hot `gnt[N]`, binary `gnt_id`, `any`.
  - Purely combinational; a double-width rotate-and-priority-encode implementation is acceptable.
- The adder is an `Add_module #(.Bits(Bits))` instance fed by the granted operand mux. Overflow is derived from the operand and sum MSBs.
- Top level holds the `last_grant` register, the output register and the accept logic.

## Test plan
- Reset release, single requester:
  - Stimulus: `req_valid=3'b001`, `a=0x0040_0000`, `b=4`, `resp_ready=1`.
  - Response: `req_ready=001` the same cycle; next cycle `resp_valid=1`, `resp_sum=0x0040_0004`, `resp_id=0`, `resp_ovf=0`.
- Round-robin:
  - Stimulus: all three requesters held valid, `resp_ready=1`.
  - Response: grants 0,1,2,0,1,2 on consecutive cycles; `resp_id` follows one cycle later; no cycle without `resp_valid` after the first.
- Backpressure:
  - Stimulus: `resp_ready=0` for 3 cycles with requesters 1 and 2 valid.
  - Response: `req_ready=000`, outputs frozen; after `resp_ready` rises, the first grant goes to `(last_grant+1)`.
- Overflow and wrap:
  - `a=0x7FFF_FFFF`, `b=1`: `resp_sum=0x8000_0000`, `resp_ovf=1`.
  - `a=0xFFFF_FFFF`, `b=1`: `resp_sum=0`, `resp_ovf=0`.
  - `a=0x8000_0000`, `b=0xFFFF_FFFF`: `resp_ovf=1`.
- Reset mid-stream:
  - Stimulus: assert `rst` for 1 cycle while `resp_valid=1` and `resp_ready=0`.
  - Response: next cycle `resp_valid=0`, `resp_sum=0`; the first post-reset grant goes to requester 0 even if requester 2 was next.
- Starvation check:
  - Stimulus: random `req_valid` and `resp_ready` (50%) for 10k cycles against a scoreboard.
  - Response: every accepted request yields exactly one correct sum with the matching ID, in grant order; no held request waits more than `N_REQ` accept windows.
